// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned LEN_BYTES = 4;
  localparam int unsigned CSUM_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Byte-to-word assembler. Shifts accepted bytes in little-endian order and
// flags the cycle in which the 4th byte of a word arrives.
//   clk, rst_n : clock, async active-low reset
//   clr        : clear counter and partial word
//   shift      : accept data_in this cycle
//   data_in    : incoming byte
//   next_word  : word including data_in (valid when full is high)
//   full       : this shift completes a word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  data_in,
  output logic [31:0] next_word,
  output logic        full
);

  logic [31:0] word;
  logic [1:0]  count;

  assign next_word = {data_in, word[31:8]};
  assign full      = shift && (count == 2'(LEN_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      count <= '0;
    end else if (clr) begin
      word  <= '0;
      count <= '0;
    end else if (shift) begin
      word  <= next_word;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed-byte program loader for instruction memory. Receives a word count,
// the data words and an XOR checksum; writes each word and holds the core
// in reset while a session is active.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_start                 : begin a session (IDLE/DONE/ERR only)
//   i_rx_data/valid, o_rx_ready : byte stream handshake
//   o_we, o_waddr, o_wdata  : instruction memory write port
//   o_cpu_hold, o_busy      : session active
//   o_done, o_err           : sticky session result
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_we,
  output logic [31:0] o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned IDX_W = $clog2(N) + 1;

  state_t              state, state_n;
  logic [IDX_W-1:0]    len;
  logic [IDX_W-1:0]    word_idx;
  logic [CSUM_W-1:0]   csum;
  logic                xfer;
  logic                start_ok;
  logic                pk_shift;
  logic                pk_full;
  logic [31:0]         pk_next;

  assign xfer     = i_rx_valid && o_rx_ready;
  assign start_ok = i_start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign pk_shift = xfer && (state == S_LEN || state == S_DATA);

  imem_word_packer u_packer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clr       (start_ok),
    .shift     (pk_shift),
    .data_in   (i_rx_data),
    .next_word (pk_next),
    .full      (pk_full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (i_start) state_n = S_LEN;
      S_LEN: begin
        if (pk_full) begin
          if (pk_next == 32'd0 || pk_next > 32'(N)) state_n = S_ERR;
          else                                     state_n = S_DATA;
        end
      end
      S_DATA:  if (pk_full) state_n = S_WRITE;
      S_WRITE: begin
        if (word_idx + IDX_W'(1) == len) state_n = S_CSUM;
        else                             state_n = S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_n = (i_rx_data == csum) ? S_DONE : S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      word_idx   <= '0;
      csum       <= '0;
      o_rx_ready <= 1'b0;
      o_we       <= 1'b0;
      o_waddr    <= '0;
      o_wdata    <= '0;
      o_cpu_hold <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_n;
      o_rx_ready <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_CSUM);
      o_busy     <= (state_n == S_LEN) || (state_n == S_DATA) ||
                    (state_n == S_WRITE) || (state_n == S_CSUM);
      o_cpu_hold <= (state_n == S_LEN) || (state_n == S_DATA) ||
                    (state_n == S_WRITE) || (state_n == S_CSUM);
      o_we       <= (state_n == S_WRITE);
      o_done     <= (state_n == S_DONE);
      o_err      <= (state_n == S_ERR);

      if (start_ok) begin
        len      <= '0;
        word_idx <= '0;
        csum     <= '0;
      end
      if (state == S_LEN && pk_full) len <= pk_next[IDX_W-1:0];
      if (state == S_DATA && xfer) csum <= csum ^ i_rx_data;
      if (state == S_DATA && pk_full) begin
        o_waddr <= {{(32 - IDX_W - 2){1'b0}}, word_idx, 2'b00};
        o_wdata <= pk_next;
      end
      if (state == S_WRITE) word_idx <= word_idx + IDX_W'(1);
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory: it accepts a framed byte stream from a host link (e.g. UART receiver), assembles little-endian 32-bit words, and drives a word-aligned write port into the instruction memory array. While loading, it holds the core in reset so the fetch side never reads a partially written image. It sits between the host byte receiver and the write side of instruction memory.

## Interface
- N, 2048, instruction memory depth in 32-bit words; largest accepted word count.
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle request to begin a load session.
- i_rx_data  input  8  incoming byte.
- i_rx_valid  input  1  i_rx_data valid.
- o_rx_ready  output  1  loader can accept a byte; a byte transfers on i_rx_valid && o_rx_ready.
- o_we  output  1  one-cycle write strobe to instruction memory.
- o_waddr  output  32  byte address of the word being written; always word-aligned, bits [1:0] = 0.
- o_wdata  output  32  word being written.
- o_cpu_hold  output  1  hold core in reset while the session is active.
- o_busy  output  1  session in progress.
- o_done  output  1  sticky: last session completed with good checksum.
- o_err  output  1  sticky: last session aborted (bad length or bad checksum).

## Operation
- Frame: 4-byte word count L (little-endian), then 4·L data bytes (each word little-endian, byte 0 → bits [7:0]), then 1 checksum byte = XOR of all 4·L data bytes.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR: i_start → LEN; clears o_done, o_err, byte counter, word index, checksum. i_start is ignored in LEN/DATA/WRITE/CSUM.
- LEN: accepts 4 bytes. After the 4th byte: if L == 0 or L > N → ERR, else → DATA.
- DATA: accepts bytes into the word assembler and XORs each into the running checksum; after the 4th byte of a word → WRITE.
- WRITE: exactly one cycle; o_we = 1, o_waddr = word_idx·4, o_wdata = assembled word; word_idx increments. Next state is CSUM if word_idx + 1 == L, else DATA.
- CSUM: accepts 1 byte; equal to running checksum → DONE, else → ERR. Words already written stay written.
- o_rx_ready = 1 only in LEN, DATA, CSUM. o_busy = o_cpu_hold = 1 in LEN, DATA, WRITE, CSUM.
- o_done = 1 only in DONE; o_err = 1 only in ERR. Both are held until the next i_start.
- Word count and word_idx are 12 bits wide (clog2(N)+1); the length compare uses all 32 received bits, so any upper byte ≠ 0 is an error.

## Timing
- Reset (asynchronous, any state, including mid-session): state IDLE; every output 0; counters and checksum cleared.
- All outputs are registered or decoded from state only. There is no combinational path from i_rx_* to any output.
- i_start in IDLE → o_busy/o_rx_ready high the next cycle.
- o_we rises in the cycle after the handshake of a word's 4th byte and lasts exactly 1 cycle. o_rx_ready is low in that cycle. A byte presented during WRITE is held by the source and is accepted in the following DATA cycle, so no byte is lost.
- Peak throughput is 4 bytes per 5 cycles. With i_rx_valid held high, L words plus overhead complete in 4 + 5L + 1 accept cycles.
- Final state transition (DONE/ERR) occurs in the cycle after the checksum handshake, or the 4th length byte for length errors.

## Structure
- Package imem_loader_pkg: state enum type; checksum width; LEN_BYTES = 4.
- Sub-module imem_word_packer: byte shift-in, 2-bit byte counter, and word_full flag. The FSM, counters and checksum stay in imem_loader.

## Test plan
- Normal load: start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, checksum 90 → writes (0x0, 0x00000013) and (0x4, 0x00100093), one cycle each; o_done=1, o_cpu_hold=0, o_err=0.
- Zero length: bytes 00 00 00 00 → o_err=1 next cycle, no o_we, o_rx_ready=0.
- Oversize length: 01 08 00 00 (2049) with N=2048 → o_err=1, no o_we; repeat with 00 00 00 01 → o_err=1.
- Bad checksum: the normal load frame with checksum 91 → both writes occur, then o_err=1, o_done=0.
- Backpressure/gaps: random i_rx_valid gaps plus a byte held valid across the WRITE cycle → identical writes to the normal-load case; o_rx_ready=0 exactly in WRITE cycles.
- Reset mid-DATA after 6 bytes → all outputs 0 immediately. A new start with the normal-load frame then reproduces the normal result; i_start pulses during a session have no effect.
